// File: rtl/alu_pkg.sv
// Definitions shared by the ALU, the command sequencer and their benches:
// opcode constants, default widths and the sequencer state encoding.
package alu_pkg;

    localparam int SIZEDATA_DEF = 8;
    localparam int SIZEOP_DEF   = 6;

    // R-type function codes
    localparam logic [SIZEOP_DEF-1:0] OP_SLL  = 6'h00;
    localparam logic [SIZEOP_DEF-1:0] OP_SRL  = 6'h02;
    localparam logic [SIZEOP_DEF-1:0] OP_SRA  = 6'h03;
    localparam logic [SIZEOP_DEF-1:0] OP_SLLV = 6'h04;
    localparam logic [SIZEOP_DEF-1:0] OP_SRLV = 6'h06;
    localparam logic [SIZEOP_DEF-1:0] OP_SRAV = 6'h07;
    localparam logic [SIZEOP_DEF-1:0] OP_ADDU = 6'h21;
    localparam logic [SIZEOP_DEF-1:0] OP_SUBU = 6'h23;
    localparam logic [SIZEOP_DEF-1:0] OP_AND  = 6'h24;
    localparam logic [SIZEOP_DEF-1:0] OP_OR   = 6'h25;
    localparam logic [SIZEOP_DEF-1:0] OP_XOR  = 6'h26;
    localparam logic [SIZEOP_DEF-1:0] OP_NOR  = 6'h27;
    localparam logic [SIZEOP_DEF-1:0] OP_SLT  = 6'h2A;

    // I-type opcodes
    localparam logic [SIZEOP_DEF-1:0] OP_ADDI = 6'h08;
    localparam logic [SIZEOP_DEF-1:0] OP_SLTI = 6'h0A;
    localparam logic [SIZEOP_DEF-1:0] OP_ANDI = 6'h0C;
    localparam logic [SIZEOP_DEF-1:0] OP_ORI  = 6'h0D;
    localparam logic [SIZEOP_DEF-1:0] OP_XORI = 6'h0E;
    localparam logic [SIZEOP_DEF-1:0] OP_LUI  = 6'h0F;

    localparam int NUM_OPS = 19;

    // Flat table of every supported opcode; slot gi lives at [gi*SIZEOP_DEF +: SIZEOP_DEF].
    localparam logic [NUM_OPS*SIZEOP_DEF-1:0] LEGAL_OPS = {
        OP_LUI,  OP_XORI, OP_ORI,  OP_ANDI, OP_SLTI, OP_ADDI,
        OP_SLT,  OP_NOR,  OP_XOR,  OP_OR,   OP_AND,  OP_SUBU, OP_ADDU,
        OP_SRAV, OP_SRLV, OP_SLLV, OP_SRA,  OP_SRL,  OP_SLL
    };

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    typedef enum logic [2:0] {
        S_WAIT_A  = ST_WAIT_A,
        S_WAIT_B  = ST_WAIT_B,
        S_WAIT_OP = ST_WAIT_OP,
        S_EXEC    = ST_EXEC,
        S_SEND    = ST_SEND,
        S_WAIT_TX = ST_WAIT_TX
    } seq_state_e;

    function automatic logic is_busy_state(input seq_state_e s);
        return (s == S_EXEC) || (s == S_SEND) || (s == S_WAIT_TX);
    endfunction

endpackage

// File: rtl/alu_op_check.sv
// Combinational legality check of a received opcode byte: the top two bits
// must be clear and the low six must match one of the supported opcodes.
module alu_op_check
    import alu_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_legal
);

    logic [NUM_OPS-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi = gi + 1) begin : g_match
            assign hit[gi] = (i_byte[5:0] == LEGAL_OPS[gi*SIZEOP_DEF +: SIZEOP_DEF]);
        end
    endgenerate

    assign o_legal = (i_byte[7:6] == 2'b00) && (|hit);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-serial ALU command sequencer: collects A, B and opcode from the UART
// receiver, runs the shared ALU and returns the result byte to the transmitter.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int SIZEDATA = SIZEDATA_DEF,
    parameter int SIZEOP   = SIZEOP_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_done,
    input  logic                i_tx_done,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_start,
    output logic [SIZEDATA-1:0] o_datoa,
    output logic [SIZEDATA-1:0] o_datob,
    output logic [SIZEOP-1:0]   o_opcode,
    input  logic [SIZEDATA-1:0] i_result,
    output logic                o_busy,
    output logic                o_err,
    output logic                o_overrun
);

    seq_state_e          state_q,    state_d;
    logic [SIZEDATA-1:0] data_a_q,   data_a_d;
    logic [SIZEDATA-1:0] data_b_q,   data_b_d;
    logic [SIZEOP-1:0]   opcode_q,   opcode_d;
    logic [SIZEDATA-1:0] result_q,   result_d;
    logic                err_q,      err_d;
    logic                overrun_q,  overrun_d;
    logic                op_legal;

    alu_op_check u_op_check (
        .i_byte  (i_rx_data),
        .o_legal (op_legal)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= S_WAIT_A;
            data_a_q  <= '0;
            data_b_q  <= '0;
            opcode_q  <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            opcode_q  <= opcode_d;
            result_q  <= result_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        opcode_d  = opcode_q;
        result_d  = result_q;
        err_d     = 1'b0;
        // Any byte arriving while the ALU/transmitter is owned is lost.
        overrun_d = i_rx_done && is_busy_state(state_q);

        case (state_q)
            S_WAIT_A: begin
                if (i_rx_done) begin
                    data_a_d = SIZEDATA'(i_rx_data);
                    state_d  = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (i_rx_done) begin
                    data_b_d = SIZEDATA'(i_rx_data);
                    state_d  = S_WAIT_OP;
                end
            end
            S_WAIT_OP: begin
                if (i_rx_done) begin
                    if (op_legal) begin
                        opcode_d = i_rx_data[SIZEOP-1:0];
                        state_d  = S_EXEC;
                    end else begin
                        // Whole command is discarded; the old opcode stays on the ALU.
                        err_d   = 1'b1;
                        state_d = S_WAIT_A;
                    end
                end
            end
            S_EXEC: begin
                result_d = i_result;
                state_d  = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = S_WAIT_A;
                end
            end
            default: begin
                state_d = S_WAIT_A;
            end
        endcase
    end

    assign o_datoa    = data_a_q;
    assign o_datob    = data_b_q;
    assign o_opcode   = opcode_q;
    assign o_tx_data  = result_q[7:0];
    assign o_tx_start = (state_q == S_SEND);
    assign o_busy     = is_busy_state(state_q);
    assign o_err      = err_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed, table-driven bench for alu_cmd_sequencer with a small stand-in ALU.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] datoa;
    logic [7:0] datob;
    logic [5:0] opcode;
    logic [7:0] result;
    logic       busy;
    logic       err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    logic [5:0] last_op;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
        bit         legal;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.SIZEDATA(8), .SIZEOP(6)) dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_rx_data  (rx_data),
        .i_rx_done  (rx_done),
        .i_tx_done  (tx_done),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .o_datoa    (datoa),
        .o_datob    (datob),
        .o_opcode   (opcode),
        .i_result   (result),
        .o_busy     (busy),
        .o_err      (err),
        .o_overrun  (overrun)
    );

    // Stand-in for the external combinational ALU (only the ops exercised here).
    always_comb begin
        result = 8'h00;
        case (opcode)
            6'h00: result = datoa << datob[2:0];
            6'h03: result = 8'($signed(datoa) >>> datob[2:0]);
            6'h21: result = datoa + datob;
            6'h23: result = datoa - datob;
            6'h24: result = datoa & datob;
            6'h26: result = datoa ^ datob;
            6'h27: result = ~(datoa | datob);
            6'h2A: result = ($signed(datoa) < $signed(datob)) ? 8'h01 : 8'h00;
            default: result = 8'h00;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp, input bit legal,
                           input bit finish);
        send_byte(a);
        check({name, "_datoa"}, datoa, a);
        send_byte(b);
        check({name, "_datob"}, datob, b);
        send_byte(op);
        if (legal) begin
            last_op = op[5:0];
            check({name, "_opcode"}, opcode, op[5:0]);
            check({name, "_exec_busy"}, busy, 1);
            check({name, "_exec_nostart"}, tx_start, 0);
            step();
            check({name, "_start"}, tx_start, 1);
            check({name, "_txdata"}, tx_data, exp);
            step();
            check({name, "_start_1cyc"}, tx_start, 0);
            check({name, "_waittx_busy"}, busy, 1);
            check({name, "_txdata_hold"}, tx_data, exp);
            if (finish) begin
                step();
                step();
                check({name, "_busy_until_done"}, busy, 1);
                tx_done = 1'b1;
                step();
                tx_done = 1'b0;
                check({name, "_idle"}, busy, 0);
            end
        end else begin
            check({name, "_err"}, err, 1);
            check({name, "_err_idle"}, busy, 0);
            check({name, "_err_nostart"}, tx_start, 0);
            check({name, "_op_kept"}, opcode, last_op);
            step();
            check({name, "_err_1cyc"}, err, 0);
            check({name, "_err_nostart2"}, tx_start, 0);
        end
    endtask

    initial begin
        vecs[0] = '{"addu",  8'h05, 8'h03, 8'h21, 8'h08, 1'b1};
        vecs[1] = '{"subu",  8'h03, 8'h05, 8'h23, 8'hFE, 1'b1};
        vecs[2] = '{"sra",   8'h80, 8'h02, 8'h03, 8'hE0, 1'b1};
        vecs[3] = '{"ill3f", 8'h11, 8'h22, 8'h3F, 8'h00, 1'b0};
        vecs[4] = '{"illc1", 8'h33, 8'h44, 8'hC1, 8'h00, 1'b0};
        vecs[5] = '{"slt",   8'h0A, 8'h14, 8'h2A, 8'h01, 1'b1};
        vecs[6] = '{"and",   8'hF0, 8'h3C, 8'h24, 8'h30, 1'b1};
        vecs[7] = '{"nor",   8'hF0, 8'h3C, 8'h27, 8'h03, 1'b1};
        vecs[8] = '{"ill61", 8'h01, 8'h02, 8'h61, 8'h00, 1'b0};

        reset_n = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        last_op = 6'h00;
        step();
        step();
        check("rst_datoa", datoa, 0);
        check("rst_datob", datob, 0);
        check("rst_opcode", opcode, 0);
        check("rst_txdata", tx_data, 0);
        check("rst_txstart", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res,
                    vecs[i].legal, 1'b1);
        end

        // Overrun while waiting for the transmitter
        run_cmd("ovr", 8'h05, 8'h03, 8'h21, 8'h08, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            rx_data = 8'hAA;
            rx_done = 1'b1;
            step();
            rx_done = 1'b0;
            check("ovr_pulse", overrun, 1);
            check("ovr_txdata", tx_data, 8'h08);
            check("ovr_busy", busy, 1);
            step();
            check("ovr_1cyc", overrun, 0);
        end
        rx_data = 8'h77;
        rx_done = 1'b1;
        tx_done = 1'b1;
        step();
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("sim_overrun", overrun, 1);
        check("sim_idle", busy, 0);
        check("sim_dropped", datoa, 8'h05);
        step();
        check("sim_ovr_1cyc", overrun, 0);

        // Reset after operand A
        send_byte(8'h7F);
        check("rsta_datoa", datoa, 8'h7F);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("rsta_datoa0", datoa, 0);
        check("rsta_datob0", datob, 0);
        check("rsta_opcode0", opcode, 0);
        check("rsta_txdata0", tx_data, 0);
        check("rsta_busy0", busy, 0);
        last_op = 6'h00;
        run_cmd("sll", 8'h01, 8'h01, 8'h00, 8'h02, 1'b1, 1'b1);

        // Reset while waiting for the transmitter
        run_cmd("xor", 8'hF0, 8'h3C, 8'h26, 8'hCC, 1'b1, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("rsttx_busy", busy, 0);
        check("rsttx_start", tx_start, 0);
        check("rsttx_txdata", tx_data, 0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("rsttx_done_nostart", tx_start, 0);
        check("rsttx_done_idle", busy, 0);
        step();
        check("rsttx_nostart2", tx_start, 0);
        send_byte(8'h55);
        check("rsttx_waita", datoa, 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
